// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: parses scan-code set 2 sequences (E0/F0 prefixes)
// into key events and buffers them in a show-ahead FIFO. A watchdog aborts
// partial prefix sequences; dropped events raise a sticky overflow flag.
module ps2_kbd_ctrl #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_done_tick,
    input  logic [7:0]               rx_data,
    output logic                     rx_en,
    output logic                     evt_valid,
    output logic [7:0]               evt_code,
    output logic                     evt_ext,
    output logic                     evt_brk,
    input  logic                     evt_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     seq_timeout
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            seq_timeout_q;
    logic            expire;
    logic            is_status;
    logic            push;
    logic [9:0]      push_entry;   // {ext, brk, code}

    logic [9:0]      mem_q [DEPTH];
    logic [9:0]      last_q;       // head value shown once the FIFO drains
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q;
    logic            full, do_push, do_pop, drop;
    logic [9:0]      head;

    // Status/ack bytes that carry no key information when seen outside a sequence
    always_comb begin
        is_status = rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
    end

    // Parser next state, event generation and watchdog expiry
    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        push_entry = {2'b00, rx_data};
        expire     = (state_q != StIdle) && !rx_done_tick && (timer_q == TMAX);
        if (rx_done_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == 8'hE0)      state_d = StExt;
                    else if (rx_data == 8'hF0) state_d = StBrk;
                    else if (!is_status)       push    = 1'b1;
                end
                StExt: begin
                    if (rx_data == 8'hF0) state_d = StExtBrk;
                    else if (rx_data != 8'hE0) begin
                        push       = 1'b1;
                        push_entry = {2'b10, rx_data};
                        state_d    = StIdle;
                    end
                end
                StBrk: begin
                    if (rx_data == 8'hE0) state_d = StExtBrk;
                    else if (rx_data != 8'hF0) begin
                        push       = 1'b1;
                        push_entry = {2'b01, rx_data};
                        state_d    = StIdle;
                    end
                end
                StExtBrk: begin
                    if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
                        push       = 1'b1;
                        push_entry = {2'b11, rx_data};
                        state_d    = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (expire) begin
            state_d = StIdle;
        end
    end

    // Inter-byte timer: runs only while a prefix sequence is open
    always_comb begin
        if (rx_done_tick || state_q == StIdle || expire) timer_d = '0;
        else                                             timer_d = timer_q + 1'b1;
    end

    // Parser state, timer and timeout pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            seq_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            seq_timeout_q <= expire;
        end
    end

    // FIFO handshake decode; a push into a full FIFO is accepted if a pop frees the slot
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        do_pop  = (count_q != '0) && evt_ready;
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers, count and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            // A drop in the same cycle as a clear keeps the flag set
            if (drop)              overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
        end
    end

    // Show-ahead outputs; hold the last popped entry while empty
    always_comb begin
        head        = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
        evt_valid   = (count_q != '0);
        evt_code    = head[7:0];
        evt_brk     = head[8];
        evt_ext     = head[9];
        fifo_count  = count_q;
        rx_en       = !full;
        overflow    = overflow_q;
        seq_timeout = seq_timeout_q;
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed, table-driven bench for ps2_kbd_ctrl (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       evt_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clr_overflow;
    logic       seq_timeout;

    int n_vec  = 0;
    int n_fail = 0;

    ps2_kbd_ctrl #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_brk      (evt_brk),
        .evt_ready    (evt_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .seq_timeout  (seq_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic [7:0] data;
        logic       rdy;
        logic       clr;
        logic       valid;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [2:0] cnt;
        logic       rxen;
        logic       ovf;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic tick, logic [7:0] data, logic rdy, logic clr,
                                logic valid, logic [7:0] code, logic ext, logic brk,
                                logic [2:0] cnt, logic rxen, logic ovf);
        vec_t v;
        v.tick = tick; v.data = data; v.rdy = rdy; v.clr = clr;
        v.valid = valid; v.code = code; v.ext = ext; v.brk = brk;
        v.cnt = cnt; v.rxen = rxen; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge
    task automatic drive(input logic tick, input logic [7:0] d, input logic rdy,
                         input logic clr);
        @(negedge clk);
        rx_done_tick = tick;
        rx_data      = d;
        evt_ready    = rdy;
        clr_overflow = clr;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic chk_evt(input string tag, input logic valid, input logic [7:0] code,
                           input logic ext, input logic brk, input logic [2:0] cnt);
        chk({tag, ".valid"}, 32'(evt_valid), 32'(valid));
        chk({tag, ".code"},  32'(evt_code),  32'(code));
        chk({tag, ".ext"},   32'(evt_ext),   32'(ext));
        chk({tag, ".brk"},   32'(evt_brk),   32'(brk));
        chk({tag, ".cnt"},   32'(fifo_count), 32'(cnt));
    endtask

    initial begin
        int pulses;
        int pulse_at;

        reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00;
        evt_ready = 1'b0; clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_evt("reset", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        chk("reset.rx_en", 32'(rx_en), 32'd1);
        chk("reset.ovf", 32'(overflow), 32'd0);
        chk("reset.to", 32'(seq_timeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //          tick data  rdy clr  valid code  ext brk cnt rxen ovf
        vq.push_back(mk(1, 8'h1C, 0, 0,  1, 8'h1C, 0, 0, 3'd1, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  0, 8'h1C, 0, 0, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'hE0, 0, 0,  0, 8'h1C, 0, 0, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'hF0, 0, 0,  0, 8'h1C, 0, 0, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'h75, 0, 0,  1, 8'h75, 1, 1, 3'd1, 1, 0));
        vq.push_back(mk(1, 8'hF0, 0, 0,  1, 8'h75, 1, 1, 3'd1, 1, 0));
        vq.push_back(mk(1, 8'h1C, 0, 0,  1, 8'h75, 1, 1, 3'd2, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  1, 8'h1C, 0, 1, 3'd1, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  0, 8'h1C, 0, 1, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'hAA, 0, 0,  0, 8'h1C, 0, 1, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'hFA, 0, 0,  0, 8'h1C, 0, 1, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'hE1, 0, 0,  0, 8'h1C, 0, 1, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'hE0, 0, 0,  0, 8'h1C, 0, 1, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'hFA, 0, 0,  1, 8'hFA, 1, 0, 3'd1, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  0, 8'hFA, 1, 0, 3'd0, 1, 0));
        // fill to DEPTH=4, overflow, push+pop while full, clear racing a drop
        vq.push_back(mk(1, 8'h11, 0, 0,  1, 8'h11, 0, 0, 3'd1, 1, 0));
        vq.push_back(mk(1, 8'h22, 0, 0,  1, 8'h11, 0, 0, 3'd2, 1, 0));
        vq.push_back(mk(1, 8'h33, 0, 0,  1, 8'h11, 0, 0, 3'd3, 1, 0));
        vq.push_back(mk(1, 8'h44, 0, 0,  1, 8'h11, 0, 0, 3'd4, 0, 0));
        vq.push_back(mk(1, 8'h55, 0, 0,  1, 8'h11, 0, 0, 3'd4, 0, 1));
        vq.push_back(mk(1, 8'h66, 1, 0,  1, 8'h22, 0, 0, 3'd4, 0, 1));
        vq.push_back(mk(1, 8'h77, 0, 1,  1, 8'h22, 0, 0, 3'd4, 0, 1));
        vq.push_back(mk(0, 8'h00, 0, 1,  1, 8'h22, 0, 0, 3'd4, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  1, 8'h33, 0, 0, 3'd3, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  1, 8'h44, 0, 0, 3'd2, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  1, 8'h66, 0, 0, 3'd1, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  0, 8'h66, 0, 0, 3'd0, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  0, 8'h66, 0, 0, 3'd0, 1, 0));
        // status byte inside a prefix is a code; BRK then E0 becomes EXT_BRK
        vq.push_back(mk(1, 8'hF0, 0, 0,  0, 8'h66, 0, 0, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'hEE, 0, 0,  1, 8'hEE, 0, 1, 3'd1, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  0, 8'hEE, 0, 1, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'hF0, 0, 0,  0, 8'hEE, 0, 1, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'hE0, 0, 0,  0, 8'hEE, 0, 1, 3'd0, 1, 0));
        vq.push_back(mk(1, 8'h12, 0, 0,  1, 8'h12, 1, 1, 3'd1, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0,  0, 8'h12, 1, 1, 3'd0, 1, 0));

        foreach (vq[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vq[i].tick, vq[i].data, vq[i].rdy, vq[i].clr);
            chk_evt(tag, vq[i].valid, vq[i].code, vq[i].ext, vq[i].brk, vq[i].cnt);
            chk({tag, ".rx_en"}, 32'(rx_en), 32'(vq[i].rxen));
            chk({tag, ".ovf"}, 32'(overflow), 32'(vq[i].ovf));
            chk({tag, ".to"}, 32'(seq_timeout), 32'd0);
        end

        // Watchdog: F0 then silence; pulse expected 16 edges after the F0 edge
        drive(1'b1, 8'hF0, 1'b0, 1'b0);
        pulses = 0; pulse_at = -1;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            if (seq_timeout) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        chk("timeout.pulses", 32'(pulses), 32'd1);
        chk("timeout.at", 32'(pulse_at), 32'd15);
        chk("timeout.noevt", 32'(evt_valid), 32'd0);
        drive(1'b1, 8'h1C, 1'b0, 1'b0);
        chk_evt("after_to", 1'b1, 8'h1C, 1'b0, 1'b0, 3'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Byte arriving exactly at expiry is processed and suppresses the timeout
        drive(1'b1, 8'hF0, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            if (seq_timeout) pulses++;
        end
        drive(1'b1, 8'h1C, 1'b0, 1'b0);
        if (seq_timeout) pulses++;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (seq_timeout) pulses++;
        chk("coincide.pulses", 32'(pulses), 32'd0);
        chk_evt("coincide", 1'b1, 8'h1C, 1'b0, 1'b1, 3'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-sequence with events queued
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 8'hE0, 1'b0, 1'b0);
        chk("pre_rst.cnt", 32'(fifo_count), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_evt("midrst", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        chk("midrst.rx_en", 32'(rx_en), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 8'h75, 1'b0, 1'b0);
        chk_evt("post_rst", 1'b1, 8'h75, 1'b0, 1'b0, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Keyboard-side controller sitting between the PS/2 byte receiver and the processor's I/O bus. It gates the receiver's enable, parses scan-code set 2 byte sequences (E0 extended prefix, F0 break prefix) into single key events, and buffers those events in a show-ahead FIFO. A watchdog aborts partial prefix sequences. Overflow is reported as a sticky flag.

Parameters:
DEPTH, 8, event FIFO entries; power of two, minimum 2
TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of one sequence (2 ms at 50 MHz); minimum 2

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
rx_done_tick  in  1  one-cycle strobe: a received byte is valid on rx_data
rx_data  in  8  received byte, sampled only when rx_done_tick=1
rx_en  out  1  enable to receiver: 1 when FIFO not full
evt_valid  out  1  FIFO not empty
evt_code  out  8  head event scan code
evt_ext  out  1  head event had E0 prefix
evt_brk  out  1  head event is a release (F0 prefix)
evt_ready  in  1  pop; head is consumed when evt_valid & evt_ready
fifo_count  out  clog2(DEPTH)+1  entries held, 0..DEPTH
overflow  out  1  sticky: an event was dropped because the FIFO was full
clr_overflow  in  1  clears overflow; a same-cycle drop wins and overflow stays 1
seq_timeout  out  1  one-cycle pulse when a partial sequence is aborted

Behaviour:
- Reset values: rx_en=1, evt_valid=0, evt_code=0, evt_ext=0, evt_brk=0, fifo_count=0, overflow=0, seq_timeout=0. Parser in IDLE, timer at 0, FIFO pointers at 0.
- Parser states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on rx_done_tick, except for a timeout.
- IDLE transitions:
  - E0 -> EXT; F0 -> BRK.
  - Status bytes 00, AA, EE, FA, FE, FF and E1 are discarded; state stays IDLE.
  - Any other byte pushes {ext=0, brk=0, code} and stays IDLE.
- EXT: F0 -> EXT_BRK; E0 -> stay in EXT; other byte pushes {1,0,code} -> IDLE.
- BRK: F0 -> stay in BRK; E0 -> EXT_BRK; other byte pushes {0,1,code} -> IDLE.
- EXT_BRK: E0 or F0 -> stay in EXT_BRK; other byte pushes {1,1,code} -> IDLE.
- Status-byte discard applies only in IDLE. In prefix states those bytes are treated as codes.
- Timer:
  - Cleared to 0 on every rx_done_tick and whenever the state is IDLE.
  - Increments each cycle while the state is not IDLE.
  - When the timer equals TIMEOUT_CYCLES-1 with no rx_done_tick that cycle: state goes to IDLE, seq_timeout pulses for 1 cycle, and nothing is pushed.
  - If rx_done_tick coincides with expiry, the byte is processed and the timeout does not fire.
- Push latency: the event becomes visible on evt_* and evt_valid on the cycle after rx_done_tick.
- FIFO:
  - Show-ahead: evt_* always reflect the head entry. evt_* hold their last value when empty (0 after reset).
  - Pop when evt_valid & evt_ready; popping while empty is ignored.
  - Push and pop in the same cycle: count unchanged. This applies even when full, so the push is accepted.
  - Push while full without a same-cycle pop: event dropped, overflow set to 1, FIFO unchanged.
  - Pointers wrap modulo DEPTH.
- rx_en = (fifo_count != DEPTH), combinational from registered count. It only stops the receiver from starting new frames; a frame already in progress may still complete, and overflow rules apply to it.
- Reset asserted mid-sequence: parser returns to IDLE, FIFO is emptied, flags are cleared. Bytes after reset release are parsed from IDLE.

Test Plan:
- Bytes 1C -> one event {code=1C, ext=0, brk=0} with evt_valid=1 next cycle, fifo_count=1. Then pop -> evt_valid=0.
- Bytes E0 F0 75 -> one event {75, ext=1, brk=1}; bytes F0 1C -> {1C, 0, 1}. FIFO order is preserved across 2 pops.
- Bytes AA, FA, E1 in IDLE -> no event, fifo_count stays 0. Byte E0 then FA -> event {FA, 1, 0}.
- With TIMEOUT_CYCLES=16: send F0, then idle 16 cycles -> seq_timeout pulses once, no event. Then 1C -> {1C, 0, 0}.
- Fill: with DEPTH=4, push 4 events -> rx_en=0, fifo_count=4.
  - A 5th byte with evt_ready=0 -> dropped, overflow=1.
  - A byte with evt_ready=1 in the same cycle -> accepted, count stays 4.
  - clr_overflow -> overflow=0.
- Reset asserted after E0 and 2 queued events -> fifo_count=0, evt_valid=0, rx_en=1. Next byte 75 after release -> {75, 0, 0}.
